// File: rtl/data_mem_responder_if.sv
// Request/response channel between the core's MEM stage and the data-memory
// responder: one valid/ready request channel and one valid/ready response channel.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store at a time, fixed access
// latency, word-granular array with misaligned/out-of-range error reporting.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 40,
    parameter int unsigned LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    data_mem_responder_if.slave bus
);

    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT_LOAD = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Power-up image: a parabola peaking at 100 in word 10, zero above word 20.
    function automatic logic [DEPTH-1:0][31:0] init_mem();
        logic [DEPTH-1:0][31:0] m;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i <= 20) begin
                m[i] = 32'(100 - (10 - i) * (10 - i));
            end else begin
                m[i] = '0;
            end
        end
        return m;
    endfunction

    // NOTE: the data array is deliberately kept out of reset so stored data
    // survives a reset pulse; its only initial state is the power-up image.
    logic [DEPTH-1:0][31:0] mem = init_mem();

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        cap_write;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_error_q;

    logic             acc_write;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic             acc_error;
    logic [IDX_W-1:0] acc_idx;
    logic             enter_resp;

    // With zero latency the access edge is the accept edge, so the live request is used.
    assign acc_write = (LATENCY == 0) ? bus.req_write : cap_write;
    assign acc_addr  = (LATENCY == 0) ? bus.req_addr  : cap_addr;
    assign acc_wdata = (LATENCY == 0) ? bus.req_wdata : cap_wdata;

    assign acc_error = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= DEPTH);
    assign acc_idx   = acc_addr[IDX_W+1:2];

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        enter_resp = 1'b0;
        case (state)
            IDLE:    enter_resp = bus.req_valid && (LATENCY == 0);
            WAIT:    enter_resp = (wait_cnt == 4'd1);
            default: enter_resp = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cap_write   <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cap_write <= bus.req_write;
                        cap_addr  <= bus.req_addr;
                        cap_wdata <= bus.req_wdata;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= LAT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    // rsp_valid follows the access edge by one cycle, giving LATENCY+1 to response.
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                rsp_error_q <= acc_error;
                rsp_rdata_q <= (acc_error || acc_write) ? '0 : mem[acc_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && enter_resp && acc_write && !acc_error) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized
// traffic against a word-array reference model; a second instance runs with LATENCY=0.
`timescale 1ns/1ps
module tb_data_mem_responder;

    localparam int DEPTH = 40;
    localparam int LAT_A = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if bus_a();
    data_mem_responder_if bus_b();

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_mem [DEPTH];

    function automatic logic [31:0] init_value(input int i);
        if (i <= 20) return 32'(100 - (10 - i) ** 2);
        return 32'd0;
    endfunction

    function automatic void model_access(input logic wr, input logic [31:0] addr,
                                         input logic [31:0] wd,
                                         output logic [31:0] rd, output logic err);
        int unsigned idx;
        idx = addr >> 2;
        err = (addr % 4 != 0) || (idx >= DEPTH);
        rd  = 32'd0;
        if (!err) begin
            if (wr) model_mem[idx] = wd;
            else    rd = model_mem[idx];
        end
    endfunction

    // One transaction on instance A; rsp_ready is held low for bp cycles once rsp_valid shows.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input int bp, output logic [31:0] rd, output logic err,
                           output int lat, output bit stable, output bit ready_back,
                           output bit timed_out);
        int waited;
        rd = 32'd0; err = 1'b0; lat = 0; stable = 1'b1; ready_back = 1'b0; timed_out = 1'b0;
        @(negedge clk);
        bus_a.req_valid = 1'b1;
        bus_a.req_write = wr;
        bus_a.req_addr  = addr;
        bus_a.req_wdata = wd;
        bus_a.rsp_ready = (bp == 0);
        waited = 0;
        while (!bus_a.req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus_a.req_ready) begin
            timed_out = 1'b1;
            bus_a.req_valid = 1'b0;
            bus_a.rsp_ready = 1'b1;
            return;
        end
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        bus_a.req_write = 1'($urandom);
        bus_a.req_addr  = $urandom;
        bus_a.req_wdata = $urandom;
        while (!bus_a.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus_a.rsp_valid) begin
            timed_out = 1'b1;
            bus_a.rsp_ready = 1'b1;
            return;
        end
        rd  = bus_a.rsp_rdata;
        err = bus_a.rsp_error;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (!bus_a.rsp_valid || bus_a.req_ready || bus_a.rsp_rdata !== rd ||
                bus_a.rsp_error !== err) stable = 1'b0;
        end
        bus_a.rsp_ready = 1'b1;
        @(negedge clk);
        ready_back = bus_a.req_ready && !bus_a.rsp_valid;
        if (bus_a.rsp_rdata !== rd || bus_a.rsp_error !== err) stable = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus_a.req_ready !== 1'b1 || bus_b.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_req_ready: got a=%b b=%b expected 1", bus_a.req_ready, bus_b.req_ready);
        end
        n_checks++;
        if (bus_a.rsp_valid !== 1'b0 || bus_b.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp_valid: got a=%b b=%b expected 0", bus_a.rsp_valid, bus_b.rsp_valid);
        end
        n_checks++;
        if (bus_a.rsp_rdata !== 32'd0 || bus_a.rsp_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp_data: got rdata=%h error=%b expected 0/0", bus_a.rsp_rdata, bus_a.rsp_error);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic err; int lat; bit st, rb, to;
        int waited;
        @(negedge clk);
        bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1;
        bus_a.req_addr = 32'h14; bus_a.req_wdata = 32'h1234; bus_a.rsp_ready = 1'b1;
        waited = 0;
        while (!bus_a.req_ready && waited < 50) begin @(negedge clk); waited++; end
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus_a.rsp_valid !== 1'b0 || bus_a.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_wait_state: got rsp_valid=%b req_ready=%b expected 0/1", bus_a.rsp_valid, bus_a.req_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus_a.rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_wait_no_rsp: got rsp_valid=%b expected 0", bus_a.rsp_valid);
            end
        end
        run_txn(1'b0, 32'h14, 32'd0, 0, rd, err, lat, st, rb, to);
        n_checks++;
        if (to || rd !== 32'd75 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_wait_dropped: got rdata=%0d error=%b timeout=%b expected 75/0/0", rd, err, to);
        end
    endtask

    task automatic test_load();
        logic [31:0] rd; logic err; int lat; bit st, rb, to;
        logic [31:0] mrd; logic merr;
        model_access(1'b0, 32'h28, 32'd0, mrd, merr);
        run_txn(1'b0, 32'h28, 32'd0, 0, rd, err, lat, st, rb, to);
        n_checks++;
        if (to || rd !== 32'h64 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL load_0x28: got rdata=%h error=%b expected 00000064/0", rd, err);
        end
        n_checks++;
        if (lat !== LAT_A + 1) begin
            n_fail++;
            $display("FAIL load_latency: got %0d expected %0d", lat, LAT_A + 1);
        end
        n_checks++;
        if (rb !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready_back: got %b expected 1", rb);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic err; int lat; bit st, rb, to;
        logic [31:0] mrd; logic merr;
        model_access(1'b1, 32'h14, 32'hDEADBEEF, mrd, merr);
        run_txn(1'b1, 32'h14, 32'hDEADBEEF, 0, rd, err, lat, st, rb, to);
        n_checks++;
        if (to || rd !== 32'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL store_0x14_rsp: got rdata=%h error=%b expected 0/0", rd, err);
        end
        run_txn(1'b0, 32'h14, 32'd0, 0, rd, err, lat, st, rb, to);
        n_checks++;
        if (to || rd !== 32'hDEADBEEF || err !== 1'b0) begin
            n_fail++;
            $display("FAIL load_after_store: got rdata=%h error=%b expected deadbeef/0", rd, err);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int lat; bit st, rb, to;
        logic [31:0] addrs [4] = '{32'hA0, 32'h06, 32'h04, 32'h9C};
        logic        wrs   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp_d [4] = '{32'd0, 32'd0, 32'd19, 32'd0};
        logic        exp_e [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] mrd; logic merr;
        for (int i = 0; i < 4; i++) begin
            model_access(wrs[i], addrs[i], 32'hFFFF_FFFF, mrd, merr);
            run_txn(wrs[i], addrs[i], 32'hFFFF_FFFF, 0, rd, err, lat, st, rb, to);
            n_checks++;
            if (to || rd !== exp_d[i] || err !== exp_e[i]) begin
                n_fail++;
                $display("FAIL error_case addr=%h: got rdata=%h error=%b expected %h/%b", addrs[i], rd, err, exp_d[i], exp_e[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic err; int lat; bit st, rb, to;
        int waited;
        @(negedge clk);
        bus_a.req_valid = 1'b1; bus_a.req_write = 1'b0;
        bus_a.req_addr = 32'h0C; bus_a.req_wdata = 32'd0; bus_a.rsp_ready = 1'b0;
        waited = 0;
        while (!bus_a.req_ready && waited < 50) begin @(negedge clk); waited++; end
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        waited = 0;
        while (!bus_a.rsp_valid && waited < 40) begin @(negedge clk); waited++; end
        bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1; bus_a.req_wdata = 32'hBAD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus_a.rsp_valid !== 1'b1 || bus_a.rsp_rdata !== 32'd51 ||
                bus_a.rsp_error !== 1'b0 || bus_a.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold cycle %0d: got valid=%b rdata=%0d error=%b req_ready=%b expected 1/51/0/0",
                         i, bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_error, bus_a.req_ready);
            end
        end
        bus_a.req_valid = 1'b0;
        bus_a.rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_a.rsp_valid !== 1'b0 || bus_a.req_ready !== 1'b1 || bus_a.rsp_rdata !== 32'd51) begin
            n_fail++;
            $display("FAIL backpressure_release: got valid=%b req_ready=%b rdata=%0d expected 0/1/51", bus_a.rsp_valid, bus_a.req_ready, bus_a.rsp_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus_a.rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_ignored_req: got rsp_valid=%b expected 0", bus_a.rsp_valid);
            end
        end
        run_txn(1'b0, 32'h0C, 32'd0, 0, rd, err, lat, st, rb, to);
        n_checks++;
        if (to || rd !== 32'd51 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_no_store: got rdata=%0d error=%b expected 51/0", rd, err);
        end
    endtask

    task automatic test_reset_mid_resp();
        logic [31:0] rd; logic err; int lat; bit st, rb, to;
        logic [31:0] mrd; logic merr;
        int waited;
        @(negedge clk);
        bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1;
        bus_a.req_addr = 32'h30; bus_a.req_wdata = 32'hCAFEF00D; bus_a.rsp_ready = 1'b0;
        waited = 0;
        while (!bus_a.req_ready && waited < 50) begin @(negedge clk); waited++; end
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        waited = 0;
        while (!bus_a.rsp_valid && waited < 40) begin @(negedge clk); waited++; end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus_a.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_resp: got rsp_valid=%b expected 0", bus_a.rsp_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus_a.rsp_ready = 1'b1;
        model_access(1'b1, 32'h30, 32'hCAFEF00D, mrd, merr);
        run_txn(1'b0, 32'h30, 32'd0, 0, rd, err, lat, st, rb, to);
        n_checks++;
        if (to || rd !== 32'hCAFEF00D || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_resp_committed: got rdata=%h error=%b expected cafef00d/0", rd, err);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic err; int lat; bit st, rb, to;
        logic [31:0] addr, wd, mrd; logic wr, merr;
        int sel, bp;
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (sel == 7) addr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            else if (sel == 8) addr = 32'($urandom_range(DEPTH, DEPTH + 20)) << 2;
            else               addr = $urandom;
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            bp = $urandom_range(0, 3);
            model_access(wr, addr, wd, mrd, merr);
            run_txn(wr, addr, wd, bp, rd, err, lat, st, rb, to);
            n_checks++;
            if (to) begin
                n_fail++;
                $display("FAIL random_timeout txn %0d: got timeout expected response", t);
            end
            n_checks++;
            if (rd !== mrd || err !== merr) begin
                n_fail++;
                $display("FAIL random_data txn %0d addr=%h wr=%b: got %h/%b expected %h/%b", t, addr, wr, rd, err, mrd, merr);
            end
            n_checks++;
            if (lat !== LAT_A + 1) begin
                n_fail++;
                $display("FAIL random_latency txn %0d: got %0d expected %0d", t, lat, LAT_A + 1);
            end
            n_checks++;
            if (st !== 1'b1 || rb !== 1'b1) begin
                n_fail++;
                $display("FAIL random_hold txn %0d: got stable=%b ready_back=%b expected 1/1", t, st, rb);
            end
        end
    endtask

    task automatic test_latency0();
        bit          has_exp [24];
        bit          exp_v   [24];
        logic [31:0] exp_d   [24];
        logic [31:0] addr;
        int last_ready, n_accepts;
        for (int i = 0; i < 24; i++) begin has_exp[i] = 1'b0; exp_v[i] = 1'b0; exp_d[i] = 32'd0; end
        last_ready = -1;
        n_accepts  = 0;
        bus_b.rsp_ready = 1'b1; bus_b.req_write = 1'b0; bus_b.req_wdata = 32'd0;
        bus_b.req_addr = 32'd0; bus_b.req_valid = 1'b1;
        for (int n = 0; n < 18; n++) begin
            @(negedge clk);
            if (has_exp[n]) begin
                n_checks++;
                if (bus_b.rsp_valid !== exp_v[n] || (exp_v[n] && (bus_b.rsp_rdata !== exp_d[n] || bus_b.rsp_error !== 1'b0))) begin
                    n_fail++;
                    $display("FAIL lat0_rsp cycle %0d: got valid=%b rdata=%0d error=%b expected %b/%0d/0", n, bus_b.rsp_valid, bus_b.rsp_rdata, bus_b.rsp_error, exp_v[n], exp_d[n]);
                end
            end
            if (bus_b.req_ready) begin
                if (last_ready >= 0) begin
                    n_checks++;
                    if (n - last_ready !== 3) begin
                        n_fail++;
                        $display("FAIL lat0_spacing: got %0d cycles expected 3", n - last_ready);
                    end
                end
                last_ready = n;
                n_accepts++;
                addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
                bus_b.req_addr = addr;
                has_exp[n + 1] = 1'b1; exp_v[n + 1] = 1'b0;
                has_exp[n + 2] = 1'b1; exp_v[n + 2] = 1'b1; exp_d[n + 2] = init_value(int'(addr >> 2));
            end
        end
        bus_b.req_valid = 1'b0;
        n_checks++;
        if (n_accepts !== 6) begin
            n_fail++;
            $display("FAIL lat0_accept_count: got %0d expected 6", n_accepts);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = init_value(i);
        bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_addr = 32'd0;
        bus_a.req_wdata = 32'd0; bus_a.rsp_ready = 1'b1;
        bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_addr = 32'd0;
        bus_b.req_wdata = 32'd0; bus_b.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_reset_mid_wait();
        test_load();
        test_store_load();
        test_errors();
        test_backpressure();
        test_reset_mid_resp();
        test_random();
        test_latency0();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        n_fail++;
        $display("FAIL watchdog: got simulation still running expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
